// File: rtl/note_scheduler.sv
// note_scheduler: arbitrates the synth key input between the live keyboard
// and a song-ROM playback sequencer. Live keys preempt playback and freeze
// its timing counters; playback resumes where it stopped.
module note_scheduler #(
  parameter int TICK_DIV  = 100000,
  parameter int GAP_TICKS = 10,
  parameter int SONG_AW   = 6
) (
  input  logic               Clock,
  input  logic               btnCpuReset,
  input  logic [7:0]         LiveCode,
  input  logic               LiveValid,
  input  logic               PlayStart,
  input  logic               PlayStop,
  output logic [SONG_AW-1:0] RomAddr,
  input  logic [15:0]        RomData,
  output logic [7:0]         KeyCode,
  output logic               Flag,
  output logic               Playing,
  output logic               LiveOwner
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0]         GAP_LAST  = 8'(GAP_TICKS - 1);
  localparam logic [SONG_AW-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_NOTE,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [SONG_AW-1:0] addr_q, addr_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         code_q, code_d;
  logic [7:0]         dur_q, dur_d;
  logic [7:0]         key_q, key_d;
  logic               flag_q, flag_d;
  logic               playing_q, playing_d;
  logic               owner_q, owner_d;
  logic               live_active;
  logic               tick_wrap;

  assign live_active = LiveValid && (LiveCode != 8'h00);
  assign tick_wrap   = (tick_q == TICK_LAST);

  // Sequencer next state: stop beats start, start beats normal progress;
  // a live key only freezes the NOTE/GAP counters.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    dur_d   = dur_q;
    if (PlayStop) begin
      state_d = S_IDLE;
      tick_d  = '0;
      cnt_d   = '0;
    end else if (PlayStart) begin
      state_d = S_FETCH;
      addr_d  = '0;
      tick_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          if (RomData[7:0] == 8'h00) begin
            state_d = S_IDLE;
          end else begin
            code_d  = RomData[15:8];
            dur_d   = RomData[7:0];
            tick_d  = '0;
            cnt_d   = '0;
            state_d = S_NOTE;
          end
        end
        S_NOTE: begin
          if (!live_active) begin
            if (tick_wrap) begin
              tick_d = '0;
              if (cnt_q == dur_q - 8'd1) begin
                cnt_d   = '0;
                state_d = S_GAP;
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        S_GAP: begin
          if (!live_active) begin
            if (tick_wrap) begin
              tick_d = '0;
              if (cnt_q == GAP_LAST) begin
                cnt_d = '0;
                if (addr_q == ADDR_LAST) begin
                  state_d = S_IDLE;
                end else begin
                  addr_d  = addr_q + SONG_AW'(1);
                  state_d = S_FETCH;
                end
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output mux: live key wins, otherwise the latched note while in NOTE.
  always_comb begin
    key_d     = 8'h00;
    owner_d   = 1'b0;
    if (live_active) begin
      key_d   = LiveCode;
      owner_d = 1'b1;
    end else if (state_q == S_NOTE) begin
      key_d   = code_q;
    end
    flag_d    = LiveValid || playing_q;
    playing_d = (state_d != S_IDLE);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (btnCpuReset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      tick_q    <= '0;
      cnt_q     <= '0;
      key_q     <= 8'h00;
      flag_q    <= 1'b0;
      playing_q <= 1'b0;
      owner_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tick_q    <= tick_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      flag_q    <= flag_d;
      playing_q <= playing_d;
      owner_q   <= owner_d;
    end
  end

  // Latched note code and duration; only read while in NOTE.
  always_ff @(posedge Clock) begin
    code_q <= code_d;
    dur_q  <= dur_d;
  end

  assign RomAddr   = addr_q;
  assign KeyCode   = key_q;
  assign Flag      = flag_q;
  assign Playing   = playing_q;
  assign LiveOwner = owner_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed song scenarios plus randomized live keys
// and start/stop pulses, checked every cycle against a countdown model.
module tb_note_scheduler;

  localparam int TD = 4;
  localparam int GT = 1;
  localparam int AW = 3;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_LOAD  = 2;
  localparam int M_NOTE  = 3;
  localparam int M_GAP   = 4;

  logic          clk = 1'b0;
  logic          rst, lv, start, stop;
  logic [7:0]    lc;
  logic [15:0]   rom_data;
  logic [AW-1:0] rom_addr;
  logic [7:0]    key;
  logic          flag, playing, owner;
  logic [15:0]   rom [8];

  always #5 clk = ~clk;

  note_scheduler #(.TICK_DIV(TD), .GAP_TICKS(GT), .SONG_AW(AW)) dut (
    .Clock      (clk),
    .btnCpuReset(rst),
    .LiveCode   (lc),
    .LiveValid  (lv),
    .PlayStart  (start),
    .PlayStop   (stop),
    .RomAddr    (rom_addr),
    .RomData    (rom_data),
    .KeyCode    (key),
    .Flag       (flag),
    .Playing    (playing),
    .LiveOwner  (owner)
  );

  // Synchronous song ROM: one cycle of read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one phase plus a single cycles-remaining countdown.
  int         m_mode = M_IDLE;
  int         m_addr = 0;
  int         m_rem  = 0;
  logic [7:0] m_code = 8'h00;
  logic [7:0] e_key  = 8'h00;
  logic       e_owner = 1'b0, e_flag = 1'b0, e_play = 1'b0;

  task automatic model_step();
    bit live;
    int d;
    live = lv && (lc != 8'h00);
    if (rst) begin
      m_mode = M_IDLE; m_addr = 0; m_rem = 0;
      e_key = 8'h00; e_owner = 1'b0; e_flag = 1'b0; e_play = 1'b0;
      return;
    end
    e_key   = live ? lc : ((m_mode == M_NOTE) ? m_code : 8'h00);
    e_owner = live;
    e_flag  = lv || e_play;
    if (stop) begin
      m_mode = M_IDLE;
    end else if (start) begin
      m_mode = M_FETCH;
      m_addr = 0;
    end else begin
      case (m_mode)
        M_FETCH: m_mode = M_LOAD;
        M_LOAD: begin
          d = int'(rom[m_addr][7:0]);
          if (d == 0) m_mode = M_IDLE;
          else begin
            m_code = rom[m_addr][15:8];
            m_rem  = d * TD;
            m_mode = M_NOTE;
          end
        end
        M_NOTE: if (!live) begin
          m_rem--;
          if (m_rem == 0) begin
            m_mode = M_GAP;
            m_rem  = GT * TD;
          end
        end
        M_GAP: if (!live) begin
          m_rem--;
          if (m_rem == 0) begin
            if (m_addr == (1 << AW) - 1) m_mode = M_IDLE;
            else begin
              m_addr++;
              m_mode = M_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
    e_play = (m_mode != M_IDLE);
  endtask

  int n1c, n1b;

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_val("KeyCode", key, e_key);
    check_val("LiveOwner", owner, e_owner);
    check_val("Flag", flag, e_flag);
    check_val("Playing", playing, e_play);
    check_val("RomAddr", rom_addr, m_addr[AW-1:0]);
    if (key == 8'h1C && !owner) n1c++;
    if (key == 8'h1B && !owner) n1b++;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic wait_key(input logic [7:0] code, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (key == code) break;
      cycle();
    end
    check_val(tag, key, code);
  endtask

  task automatic load_song();
    for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
    rom[0] = {8'h1C, 8'd2};
    rom[1] = {8'h1B, 8'd1};
    rom[2] = {8'h00, 8'd0};
  endtask

  initial begin
    rst = 1'b1; lv = 1'b0; lc = 8'h00; start = 1'b0; stop = 1'b0;
    load_song();

    // 1: reset, idle, live path
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check_val("rst_key", key, 8'h00);
    check_val("rst_flag", flag, 1'b0);
    check_val("rst_play", playing, 1'b0);
    check_val("rst_addr", rom_addr, 3'd0);
    lv = 1'b1; lc = 8'h0D;
    cycle();
    check_val("live_key", key, 8'h0D);
    check_val("live_owner", owner, 1'b1);
    check_val("live_flag", flag, 1'b1);
    lv = 1'b0; lc = 8'h00;
    repeat (2) cycle();

    // 2: full playback
    n1c = 0; n1b = 0;
    pulse_start();
    repeat (45) cycle();
    check_val("play_n1c", n1c, 8);
    check_val("play_n1b", n1b, 4);
    check_val("play_end_playing", playing, 1'b0);
    check_val("play_end_addr", rom_addr, 3'd2);

    // 3: live preempt mid-note
    n1c = 0;
    pulse_start();
    wait_key(8'h1C, 10, "pre_wait_1c");
    repeat (3) cycle();
    lv = 1'b1; lc = 8'h1D;
    repeat (10) cycle();
    check_val("pre_key", key, 8'h1D);
    check_val("pre_owner", owner, 1'b1);
    lv = 1'b0; lc = 8'h00;
    repeat (30) cycle();
    check_val("pre_n1c", n1c, 8);

    // 4: stop wins over start; restart during 0x1B
    start = 1'b1; stop = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0;
    cycle();
    check_val("both_idle", playing, 1'b0);
    pulse_start();
    wait_key(8'h1B, 40, "rs_wait_1b");
    pulse_start();
    check_val("rs_addr", rom_addr, 3'd0);
    wait_key(8'h1C, 10, "rs_wait_1c");
    stop = 1'b1; cycle(); stop = 1'b0;
    cycle();

    // 5: no terminator, stop at last address
    for (int i = 0; i < 8; i++) rom[i] = {8'h20 + 8'(i), 8'd1};
    repeat (2) cycle();
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (!playing) break;
      cycle();
    end
    check_val("end_playing", playing, 1'b0);
    check_val("end_addr", rom_addr, 3'd7);
    cycle();
    check_val("end_addr_hold", rom_addr, 3'd7);

    // 6: reset mid-note
    load_song();
    repeat (2) cycle();
    pulse_start();
    wait_key(8'h1C, 10, "mr_wait_1c");
    rst = 1'b1; cycle(); rst = 1'b0;
    check_val("mr_key", key, 8'h00);
    check_val("mr_play", playing, 1'b0);
    check_val("mr_addr", rom_addr, 3'd0);
    cycle();

    // Randomized traffic against the model
    rst = 1'b1;
    for (int i = 0; i < 8; i++)
      rom[i] = {8'($urandom_range(1, 255)),
                ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 3))};
    repeat (2) cycle();
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 60) == 0);
      stop  = ($urandom_range(0, 150) == 0);
      rst   = ($urandom_range(0, 800) == 0);
      if ($urandom_range(0, 15) == 0) begin
        lv = ~lv;
        lc = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      end
      cycle();
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Arbitrates the single `DecoderAndSynth` key input between two requesters: the live PS/2 keyboard path and a song-playback sequencer that reads (code, duration) entries from a synchronous song ROM. Live keys always preempt playback. Playback freezes while a live key is held and resumes where it stopped. Sits between the keyboard decoder / song ROM and `DecoderAndSynth`, driving its `KeyCode` and `Flag` inputs.

## Interface
- `TICK_DIV`, 100000: clock cycles per duration tick (1 ms at 100 MHz); must be ≥ 2.
- `GAP_TICKS`, 10: silent ticks inserted after every played note; must be ≥ 1.
- `SONG_AW`, 6: song ROM address width.

- `Clock`  in  1  system clock; all logic on rising edge.
- `btnCpuReset`  in  1  synchronous reset, active-high.
- `LiveCode`  in  8  keyboard scan code; 8'h00 = no key.
- `LiveValid`  in  1  `LiveCode` qualifier.
- `PlayStart`  in  1  one-cycle pulse: start the song from address 0.
- `PlayStop`  in  1  one-cycle pulse: abort playback.
- `RomAddr`  out  SONG_AW  song ROM address (registered).
- `RomData`  in  16  {code[15:8], duration[7:0]}, valid one cycle after `RomAddr`; duration 0 = end of song.
- `KeyCode`  out  8  key code to `DecoderAndSynth` (registered).
- `Flag`  out  1  `KeyCode` qualifier to `DecoderAndSynth` (registered).
- `Playing`  out  1  sequencer is not IDLE (registered).
- `LiveOwner`  out  1  1 = current `KeyCode` comes from the live keyboard (registered).

## Operation
- live_active = `LiveValid` && `LiveCode` != 0.
- States:
  - IDLE: nothing playing.
  - FETCH: `RomAddr` driven; wait for ROM latency.
  - LOAD: capture `RomData`. If duration is 0, go to IDLE. Otherwise latch code and duration, clear counters, go to NOTE.
  - NOTE: stay for duration × `TICK_DIV` cycles, then clear counters and go to GAP.
  - GAP: stay for `GAP_TICKS` × `TICK_DIV` cycles. Then:
    - If `RomAddr` = 2^SONG_AW−1, go to IDLE (no wrap).
    - Otherwise increment `RomAddr` and go to FETCH.
- Counters: tick counter 0..`TICK_DIV`−1 plus a tick count (8 bits, sized to cover `GAP_TICKS`). Both hold while live_active in NOTE/GAP. Paused cycles do not count.
- FETCH/LOAD proceed regardless of live_active. A live key only blocks counting.
- Start and stop handling:
  - `PlayStart` in any state: `RomAddr` ← 0, go to FETCH. This restarts the song if it is already playing.
  - `PlayStop`: go to IDLE.
  - Both asserted in the same cycle: stop wins.
- Output mux, registered:
  - If live_active: `KeyCode` = `LiveCode`, `LiveOwner` = 1.
  - Else if in NOTE: `KeyCode` = latched code, `LiveOwner` = 0.
  - Otherwise: `KeyCode` = 8'h00, `LiveOwner` = 0.
  - `Flag` = `LiveValid` || `Playing`.
- Reset values: state IDLE, `RomAddr` 0, `KeyCode` 8'h00, `Flag` 0, `Playing` 0, `LiveOwner` 0, all counters 0. Reset mid-note silences the output on the next cycle.

## Timing
- Live path latency: 1 cycle from `LiveCode`/`LiveValid` to `KeyCode`/`LiveOwner`/`Flag`.
- Playback start, with E = the edge that samples `PlayStart`:
  - After E: state FETCH, `RomAddr` = 0, `Playing` = 1.
  - After E+1: state LOAD.
  - After E+2: state NOTE. `KeyCode` shows the note code after E+3, because the output register samples NOTE.
- Note length: `KeyCode` holds the code for exactly duration × `TICK_DIV` cycles when no live key intervenes. It then reads 8'h00 for `GAP_TICKS` × `TICK_DIV` + 2 cycles: the gap plus FETCH and LOAD.
- Live release mid-note: the note resumes on the next cycle with its remaining count intact.
- End of song: `Playing` falls 1 cycle after LOAD sees duration 0, or 1 cycle after the final GAP ends.

## Test plan
Bench parameters: `TICK_DIV`=4, `GAP_TICKS`=1, `SONG_AW`=3. ROM contents: {0x1C,2}, {0x1B,1}, {0x00,0}.

1. Reset then idle: hold `btnCpuReset`=1 for 3 cycles, release → all outputs 0. `LiveCode`=0x0D with `LiveValid`=1 → `KeyCode`=0x0D, `LiveOwner`=1, `Flag`=1 one cycle later.
2. Playback: pulse `PlayStart` → `KeyCode`=0x1C for 8 cycles, 0x00 for 6, then 0x1B for 4, 0x00 for 6. `Playing` then drops at the duration-0 entry; `RomAddr` stops at 2.
3. Preempt: live 0x1D held for 10 cycles mid-way through 0x1C → `KeyCode`=0x1D, `LiveOwner`=1. After release, 0x1C returns for its remaining cycles; total 0x1C cycles = 8.
4. Stop versus start: `PlayStart` and `PlayStop` in the same cycle → stays IDLE. `PlayStart` during 0x1B → `RomAddr`=0 and 0x1C plays again.
5. Address end: 8-entry ROM with no terminator → after entry 7's GAP, `Playing`=0 and `RomAddr` stays at 7.
6. Reset mid-note: `btnCpuReset` pulse during 0x1C → next cycle `KeyCode`=0x00, `Playing`=0, `RomAddr`=0.
